// File: rtl/input_unit_rx_fsm.sv
// Router input unit: answers upstream req with a one-cycle ack when the FIFO has room, then buffers flits until the tail.
// Flits appear on o_flit one cycle after push; a full FIFO drops flits (sticky o_err). Optional idle timeout: RX_TIMEOUT_EN.
package router_pkg;
  typedef logic [31:0] FLIT_t;
  typedef enum logic [1:0] {HEAD_FLIT, BODY_FLIT, TAIL_FLIT} FLIT_TYPE_t;
  typedef enum logic [1:0] {IDLE, WAITING, ROUTING, ACTIVE} GLOBAL_STATE_t;
  typedef enum logic {PORT_FREE, PORT_OCCUPIED} PORT_STATUS_t;
endpackage

module input_unit_rx_fsm
  import router_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ACK_THRESH     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_upstream_req,
  output logic                   o_upstream_ack,
  input  FLIT_t                  i_flit,
  input  logic                   i_flit_valid,
  input  FLIT_TYPE_t             i_flit_type,
  output FLIT_t                  o_flit,
  output logic                   o_flit_valid,
  input  logic                   i_switch_pop,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output GLOBAL_STATE_t          o_gstate,
  output PORT_STATUS_t           o_port_status,
  output logic                   o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  GLOBAL_STATE_t state_q, state_d;
  FLIT_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          err_q;
  logic          pkt_started;
  logic          push_vld, pop_vld, drop, proto_err, timeout;

  assign pop_vld = i_switch_pop && (count != '0);

  always_comb begin
    state_d        = state_q;
    o_upstream_ack = 1'b0;
    push_vld       = 1'b0;
    drop           = 1'b0;
    proto_err      = 1'b0;
    case (state_q)
      IDLE: begin
        drop = i_flit_valid;
        if (i_upstream_req) state_d = WAITING;
      end
      WAITING: begin
        // Ack depends only on state and registered count, never on req.
        drop           = i_flit_valid;
        o_upstream_ack = (CW'(DEPTH) - count) >= CW'(ACK_THRESH);
        if (o_upstream_ack)      state_d = ACTIVE;
        else if (!i_upstream_req) state_d = IDLE;
      end
      ACTIVE: begin
        if (i_flit_valid) begin
          if ((count < CW'(DEPTH)) || i_switch_pop) push_vld = 1'b1;
          else                                      drop     = 1'b1;
          // The packet's first flit is expected to be a head; a later head is a protocol error.
          proto_err = (i_flit_type == HEAD_FLIT) && pkt_started;
          if (push_vld && (i_flit_type == TAIL_FLIT)) state_d = IDLE;
        end
        if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout = (state_q == ACTIVE) && !i_flit_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  idle_cnt <= '0;
    else if ((state_q != ACTIVE) || i_flit_valid) idle_cnt <= '0;
    else                                        idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // Timeout disabled: ACTIVE waits for the tail indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES < 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      pkt_started <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | drop | proto_err | timeout;
      if (state_q != ACTIVE)  pkt_started <= 1'b0;
      else if (i_flit_valid)  pkt_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= i_flit;
  end

  assign o_flit        = (count != '0) ? mem[rd_ptr] : '0;
  assign o_flit_valid  = (count != '0);
  assign o_fifo_count  = count;
  assign o_gstate      = state_q;
  assign o_port_status = (state_q == IDLE) ? PORT_FREE : PORT_OCCUPIED;
  assign o_err         = err_q;

endmodule
